// File: rtl/register_universal_if.sv
// Control/data bundle for register_universal: the master drives the controls, the slave returns the
// registered word and its flags.
interface register_universal_if #(
  parameter int unsigned WIDTH = 8
);
  logic             input_clock_enable;
  logic             input_clear;
  logic [2:0]       input_mode;
  logic [WIDTH-1:0] input_d;
  logic             input_serial;
  logic [WIDTH-1:0] output_q;
  logic             output_carry;
  logic             output_zero;

  modport master (
    output input_clock_enable, input_clear, input_mode, input_d, input_serial,
    input  output_q, output_carry, output_zero
  );

  modport slave (
    input  input_clock_enable, input_clear, input_mode, input_d, input_serial,
    output output_q, output_carry, output_zero
  );
endinterface

// File: rtl/register_universal.sv
// Universal WIDTH-bit register: load, increment/decrement, shift/rotate with carry and zero flags.
// Shift/rotate modes are compiled only when REGISTER_UNIVERSAL_SHIFT_EN is defined; otherwise they hold.
module register_universal #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic               clock,
  input  logic               input_reset_n,
  register_universal_if.slave bus
);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_LOAD  = 3'b001,
    MODE_INC   = 3'b010,
    MODE_DEC   = 3'b011,
    MODE_SHL   = 3'b100,
    MODE_SHR   = 3'b101,
    MODE_ROL   = 3'b110,
    MODE_ROR   = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             carry;
  logic             carry_next;

  // Carry/borrow comes from the extra top bit of a WIDTH+1 wide add/subtract.
  always_comb begin
    q_next     = q;
    carry_next = carry;
    case (mode_e'(bus.input_mode))
      MODE_LOAD: begin
        q_next     = bus.input_d;
        carry_next = 1'b0;
      end
      MODE_INC: {carry_next, q_next} = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
      MODE_DEC: {carry_next, q_next} = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
`ifdef REGISTER_UNIVERSAL_SHIFT_EN
      MODE_SHL: {carry_next, q_next} = {q, bus.input_serial};
      MODE_SHR: {q_next, carry_next} = {bus.input_serial, q};
      MODE_ROL: {carry_next, q_next} = {q, q[WIDTH-1]};
      MODE_ROR: {q_next, carry_next} = {q[0], q};
`endif
      default: ;
    endcase
  end

`ifndef REGISTER_UNIVERSAL_SHIFT_EN
  logic unused_serial;
  assign unused_serial = bus.input_serial;
`endif

  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      q     <= RESET_VALUE;
      carry <= 1'b0;
    end else if (bus.input_clear) begin
      q     <= RESET_VALUE;
      carry <= 1'b0;
    end else if (bus.input_clock_enable) begin
      q     <= q_next;
      carry <= carry_next;
    end
  end

  assign bus.output_q     = q;
  assign bus.output_carry = carry;
  assign bus.output_zero  = (q == '0);

endmodule
